// File: rtl/pool_ctrl_pkg.sv
// pool_ctrl_pkg
// Shared types and geometry helpers for the max-pooling frame controller
// and the pooling layer instances that must agree with it on output size
// and crop margins.
//   pool_state_e : frame sequencer states
//   out_dim()    : pooled output size along one axis
//   crop()       : trailing input pixels along one axis that no window covers
package pool_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_e;

    function automatic int out_dim(input int in_dim, input int k, input int s);
        return (in_dim - k) / s + 1;
    endfunction

    function automatic int crop(input int in_dim, input int k, input int s);
        return (in_dim - k) % s;
    endfunction

endpackage

// File: rtl/pool_pos_counter.sv
// pool_pos_counter
// Raster-order row/column position of the next input pixel.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clr               : synchronous clear to (0,0), wins over en
//   en                : advance one pixel (column first, then row)
//   row_idx, col_idx  : current position
//   last_col          : col_idx is the final column
//   last_row          : row_idx is the final row
//   crop              : current pixel lies in the uncovered right/bottom margin
module pool_pos_counter #(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int CROP_COL = 0,
    parameter int CROP_ROW = 0,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] row_idx,
    output logic [CNT_W-1:0] col_idx,
    output logic             last_col,
    output logic             last_row,
    output logic             crop
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);
    // First column/row of the crop margin; equals WIDTH/HEIGHT (never
    // reached) when the stride tiles the frame exactly.
    localparam logic [CNT_W-1:0] CROP_COL_START = CNT_W'(WIDTH - CROP_COL);
    localparam logic [CNT_W-1:0] CROP_ROW_START = CNT_W'(HEIGHT - CROP_ROW);

    assign last_col = (col_idx == LAST_COL);
    assign last_row = (row_idx == LAST_ROW);
    assign crop     = (col_idx >= CROP_COL_START) || (row_idx >= CROP_ROW_START);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (en) begin
            if (last_col) begin
                col_idx <= '0;
                row_idx <= last_row ? '0 : row_idx + 1'b1;
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl
// Frame sequencer between the input FWFT pixel FIFO and the max-pooling
// datapath. Pops one frame of IN_HEIGHT x IN_WIDTH pixels, drops the
// right/bottom margin no pooling window covers, then waits for the last
// pooled output before pulsing done.
//
// Handshake: a pixel moves FIFO -> pooling in any cycle where fifo_rd_en is
// high; fifo_rd_en is only raised when the FIFO is non-empty (valid),
// downstream is not almost full, and either the pooling line buffer asks
// for a pixel (ready) or the pixel is a crop pixel that is popped and
// dropped. pool_i_valid marks the popped pixels the datapath must consume;
// it is combinational so data passes with zero added latency.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : frame start pulse, accepted in IDLE only
//   abort                 : return to IDLE from any state, no done
//   fifo_empty/fifo_rd_en : input FIFO status / pop
//   pool_rd_req           : pooling line buffer wants a pixel
//   pool_i_valid          : pixel valid into pooling datapath
//   pool_o_valid          : one pulse per pooled output
//   down_almost_full      : downstream back-pressure, stalls popping
//   busy                  : RUN or DRAIN
//   done                  : one-cycle frame-complete pulse
//   err                   : sticky, pool_o_valid seen outside a frame
//   row_idx, col_idx      : position of the next input pixel
//   out_cnt               : pooled outputs seen this frame
//   state_dbg             : current sequencer state
module pool_frame_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int  IN_WIDTH  = 32,
    parameter int  IN_HEIGHT = 32,
    parameter int  KERNEL    = 2,
    parameter int  STRIDE    = 2,
    localparam int OUT_W     = out_dim(IN_WIDTH, KERNEL, STRIDE),
    localparam int OUT_H     = out_dim(IN_HEIGHT, KERNEL, STRIDE),
    localparam int OUT_TOTAL = OUT_W * OUT_H,
    localparam int CNT_W     = $clog2(((IN_WIDTH > IN_HEIGHT) ? IN_WIDTH : IN_HEIGHT) + 1),
    localparam int OCNT_W    = $clog2(OUT_TOTAL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              pool_rd_req,
    output logic              pool_i_valid,
    input  logic              pool_o_valid,
    input  logic              down_almost_full,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  row_idx,
    output logic [CNT_W-1:0]  col_idx,
    output logic [OCNT_W-1:0] out_cnt,
    output pool_state_e       state_dbg
);

    localparam int CROP_COL = crop(IN_WIDTH, KERNEL, STRIDE);
    localparam int CROP_ROW = crop(IN_HEIGHT, KERNEL, STRIDE);
    localparam logic [OCNT_W-1:0] OUT_ALL  = OCNT_W'(OUT_TOTAL);
    localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_TOTAL - 1);

    pool_state_e       state_q;
    pool_state_e       state_d;
    logic [OCNT_W-1:0] out_cnt_q;
    logic              err_q;
    logic              last_col;
    logic              last_row;
    logic              crop_px;
    logic              start_ok;
    logic              cnt_clr;
    logic              final_pop;
    logic              out_hit;
    logic              in_frame;

    assign start_ok = (state_q == IDLE) && start && !abort;
    assign cnt_clr  = abort || start_ok;
    assign in_frame = (state_q == RUN) || (state_q == DRAIN);

    assign fifo_rd_en   = (state_q == RUN) && !fifo_empty && !down_almost_full
                        && (crop_px || pool_rd_req);
    assign pool_i_valid = fifo_rd_en && !crop_px;
    assign final_pop    = fifo_rd_en && last_col && last_row;

    // Covers both the final output arriving earlier (during RUN) and it
    // arriving in this very DRAIN cycle.
    assign out_hit = (out_cnt_q == OUT_ALL) || (pool_o_valid && (out_cnt_q == OUT_LAST));

    pool_pos_counter #(
        .WIDTH    (IN_WIDTH),
        .HEIGHT   (IN_HEIGHT),
        .CROP_COL (CROP_COL),
        .CROP_ROW (CROP_ROW),
        .CNT_W    (CNT_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (fifo_rd_en),
        .row_idx  (row_idx),
        .col_idx  (col_idx),
        .last_col (last_col),
        .last_row (last_row),
        .crop     (crop_px)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)     state_d = RUN;
                RUN:     if (final_pop) state_d = DRAIN;
                DRAIN:   if (out_hit)   state_d = DONE;
                DONE:                   state_d = IDLE;
                default:                state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            out_cnt_q <= '0;
        end else if (pool_o_valid && in_frame) begin
            out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    // A stray output in the same cycle as an accepted start still counts
    // as an error; the set takes priority over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pool_o_valid && !in_frame) begin
            err_q <= 1'b1;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end
    end

    assign busy      = in_frame;
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign out_cnt   = out_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Bench for pool_frame_ctrl: a 4x4 instance (u0, no crop) and a 5x5
// instance (u1, one crop column and row) with K=2, S=2. One instance runs
// a frame at a time while the other idles with inputs low.
module tb_pool_frame_ctrl;
    import pool_ctrl_pkg::*;

    localparam int K  = 2;
    localparam int S  = 2;
    localparam int CW = 3;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start, abort, fifo_empty, pool_rd_req, pool_o_valid, daf;
    logic [1:0] fifo_rd_en, pool_i_valid, busy, done, err;
    logic [CW-1:0] row_idx [2];
    logic [CW-1:0] col_idx [2];
    logic [OW-1:0] out_cnt [2];
    pool_state_e   state_dbg [2];

    always #5 clk = ~clk;

    pool_frame_ctrl #(.IN_WIDTH(4), .IN_HEIGHT(4), .KERNEL(K), .STRIDE(S)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
        .pool_rd_req(pool_rd_req[0]), .pool_i_valid(pool_i_valid[0]),
        .pool_o_valid(pool_o_valid[0]), .down_almost_full(daf[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]),
        .row_idx(row_idx[0]), .col_idx(col_idx[0]), .out_cnt(out_cnt[0]),
        .state_dbg(state_dbg[0])
    );

    pool_frame_ctrl #(.IN_WIDTH(5), .IN_HEIGHT(5), .KERNEL(K), .STRIDE(S)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
        .pool_rd_req(pool_rd_req[1]), .pool_i_valid(pool_i_valid[1]),
        .pool_o_valid(pool_o_valid[1]), .down_almost_full(daf[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]),
        .row_idx(row_idx[1]), .col_idx(col_idx[1]), .out_cnt(out_cnt[1]),
        .state_dbg(state_dbg[1])
    );

    // ---------------- reference model ----------------
    int wdt [2] = '{4, 5};
    int hgt [2] = '{4, 5};
    pool_state_e m_phase [2];
    int          m_pix   [2];   // pixels popped so far, linear raster index
    int          m_out   [2];
    bit          m_err   [2];

    // scoreboard: {row,col} of every pixel that must reach the datapath
    logic [5:0] exp_q [$];

    int n_total = 0;
    int n_bad   = 0;
    int pops_obs, iv_obs, done_obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int out_total(input int d);
        return ((wdt[d] - K) / S + 1) * ((hgt[d] - K) / S + 1);
    endfunction

    function automatic bit is_crop(input int d, input int r, input int c);
        return (c >= wdt[d] - (wdt[d] - K) % S) || (r >= hgt[d] - (hgt[d] - K) % S);
    endfunction

    function automatic bit exp_rd(input int d);
        bit crp;
        crp = is_crop(d, m_pix[d] / wdt[d], m_pix[d] % wdt[d]);
        return (m_phase[d] == RUN) && !fifo_empty[d] && !daf[d] && (crp || pool_rd_req[d]);
    endfunction

    task automatic check_dut(input int d);
        int  r, c;
        bit  e_rd, e_iv;
        logic [5:0] pos;
        r    = m_pix[d] / wdt[d];
        c    = m_pix[d] % wdt[d];
        e_rd = exp_rd(d);
        e_iv = e_rd && !is_crop(d, r, c);
        check($sformatf("u%0d.fifo_rd_en", d), 32'(fifo_rd_en[d]), 32'(e_rd));
        check($sformatf("u%0d.pool_i_valid", d), 32'(pool_i_valid[d]), 32'(e_iv));
        check($sformatf("u%0d.busy", d), 32'(busy[d]),
              32'(m_phase[d] == RUN || m_phase[d] == DRAIN));
        check($sformatf("u%0d.done", d), 32'(done[d]), 32'(m_phase[d] == DONE));
        check($sformatf("u%0d.err", d), 32'(err[d]), 32'(m_err[d]));
        check($sformatf("u%0d.row_idx", d), 32'(row_idx[d]), 32'(r));
        check($sformatf("u%0d.col_idx", d), 32'(col_idx[d]), 32'(c));
        check($sformatf("u%0d.out_cnt", d), 32'(out_cnt[d]), 32'(m_out[d]));
        check($sformatf("u%0d.state", d), 32'(state_dbg[d]), 32'(m_phase[d]));
        if (fifo_rd_en[d] === 1'b1) pops_obs++;
        if (done[d] === 1'b1) done_obs++;
        if (pool_i_valid[d] === 1'b1) begin
            iv_obs++;
            pos = {row_idx[d], col_idx[d]};
            if (exp_q.size() == 0) check($sformatf("u%0d.iv_extra", d), 32'(1), 32'(0));
            else check($sformatf("u%0d.iv_pos", d), 32'(pos), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic model_update(input int d);
        bit rd;
        rd = exp_rd(d);
        if (rst) begin
            m_phase[d] = IDLE; m_pix[d] = 0; m_out[d] = 0; m_err[d] = 0;
        end else if (abort[d]) begin
            if (pool_o_valid[d] && (m_phase[d] == IDLE || m_phase[d] == DONE)) m_err[d] = 1;
            m_phase[d] = IDLE; m_pix[d] = 0; m_out[d] = 0;
            exp_q.delete();
        end else begin
            case (m_phase[d])
                IDLE: begin
                    if (start[d]) begin
                        m_phase[d] = RUN; m_pix[d] = 0; m_out[d] = 0; m_err[d] = 0;
                        exp_q.delete();
                        for (int k = 0; k < wdt[d] * hgt[d]; k++)
                            if (!is_crop(d, k / wdt[d], k % wdt[d]))
                                exp_q.push_back(6'((k / wdt[d]) * 8 + (k % wdt[d])));
                    end
                    if (pool_o_valid[d]) m_err[d] = 1;
                end
                RUN: begin
                    if (rd) begin
                        m_pix[d]++;
                        if (m_pix[d] == wdt[d] * hgt[d]) begin
                            m_pix[d] = 0; m_phase[d] = DRAIN;
                        end
                    end
                    if (pool_o_valid[d]) m_out[d]++;
                end
                DRAIN: begin
                    if (pool_o_valid[d]) m_out[d]++;
                    if (m_out[d] == out_total(d)) m_phase[d] = DONE;
                end
                default: begin
                    if (pool_o_valid[d]) m_err[d] = 1;
                    m_phase[d] = IDLE;
                end
            endcase
        end
    endtask

    // one clock: check outputs mid-cycle, advance the model, pass the edge
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int d = 0; d < 2; d++) model_update(d);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = '0; abort = '0; fifo_empty = '0; pool_rd_req = '0;
        pool_o_valid = '0; daf = '0;
    endtask

    // ---------------- driver ----------------
    task automatic run_frame(input int d, input int p_stall, input int abort_at,
                             input bit rst_drain, input bit daf_burst);
        int budget = 0;
        int burst  = 0;
        bit burst_done = 0;
        bit aborted = 0;
        pops_obs = 0; iv_obs = 0; done_obs = 0;
        clear_inputs();
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        while (m_phase[d] != IDLE && budget < 2000) begin
            fifo_empty[d]  = ($urandom_range(0, 99) < p_stall);
            pool_rd_req[d] = !($urandom_range(0, 99) < p_stall);
            if (daf_burst && !burst_done && m_phase[d] == RUN && m_pix[d] == 2) begin
                burst = 3; burst_done = 1;
            end
            if (burst > 0) begin
                fifo_empty[d] = 1'b0; pool_rd_req[d] = 1'b1;
            end
            daf[d] = (burst > 0) || ($urandom_range(0, 99) < p_stall / 4);
            if (burst > 0) burst--;
            pool_o_valid[d] = (m_phase[d] == RUN || m_phase[d] == DRAIN)
                              && (m_out[d] < out_total(d))
                              && !(rst_drain && m_phase[d] == RUN)
                              && ($urandom_range(0, 99) < ((m_phase[d] == DRAIN) ? 50 : 8));
            start[d] = ($urandom_range(0, 99) < 10);
            abort[d] = (abort_at >= 0) && !aborted && m_phase[d] == RUN && m_pix[d] == abort_at;
            if (abort[d]) aborted = 1;
            rst = rst_drain && (m_phase[d] == DRAIN);
            step();
            rst = 1'b0;
            budget++;
        end
        clear_inputs();
        if (budget >= 2000) check($sformatf("u%0d.timeout", d), 32'(1), 32'(0));
        if (!aborted && !rst_drain) begin
            check($sformatf("u%0d.frame_pops", d), 32'(pops_obs), 32'(wdt[d] * hgt[d]));
            check($sformatf("u%0d.frame_valid", d), 32'(iv_obs), 32'(exp_q.size() + iv_obs));
            check($sformatf("u%0d.q_left", d), 32'(exp_q.size()), 32'(0));
            check($sformatf("u%0d.done_cnt", d), 32'(done_obs), 32'(1));
        end else begin
            check($sformatf("u%0d.no_done", d), 32'(done_obs), 32'(0));
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = IDLE; m_pix[d] = 0; m_out[d] = 0; m_err[d] = 0;
        end
        @(posedge clk);
        #1;
        step();                       // reset values
        rst = 1'b0;
        step();

        run_frame(0, 0, -1, 0, 0);    // clean 4x4
        check("u0.valid_4x4", 32'(iv_obs), 32'(16));
        run_frame(1, 0, -1, 0, 0);    // clean 5x5 with crop margin
        check("u1.valid_5x5", 32'(iv_obs), 32'(16));
        check("u1.pops_5x5", 32'(pops_obs), 32'(25));
        run_frame(0, 0, -1, 0, 1);    // back-pressure burst mid-row
        run_frame(0, 20, 7, 0, 0);    // abort after 7 pops
        run_frame(0, 20, -1, 0, 0);   // full frame after abort

        // stray output while idle: err set and held, next start clears it
        pool_o_valid[0] = 1'b1;
        step();
        pool_o_valid[0] = 1'b0;
        step();
        step();
        run_frame(0, 10, -1, 0, 0);

        // reset while draining, then a late output sets err
        run_frame(1, 10, -1, 1, 0);
        pool_o_valid[1] = 1'b1;
        step();
        pool_o_valid[1] = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            run_frame(d, int'($urandom_range(0, 40)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                      0, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_frame_ctrl.md
# pool_frame_ctrl

Frame-level sequencer for the 2-D max-pooling engine. It sits between the input pixel FIFO and the pooling datapath (line buffer plus comparators). Per frame it:
- gates FIFO reads against pooling read requests and downstream back-pressure;
- discards leftover rows and columns that no pooling window covers;
- counts pooled outputs and signals frame completion.

It replaces ad-hoc crop counters inside the pooling layer with one controlled start/busy/done sequence.

## Interface
Parameters:
- IN_WIDTH, 32, input frame columns (≥ KERNEL)
- IN_HEIGHT, 32, input frame rows (≥ KERNEL)
- KERNEL, 2, square pooling window size
- STRIDE, 2, pooling stride (both axes)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; accepted only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- fifo_empty  in  1  input FWFT FIFO empty
- fifo_rd_en  out  1  pop input FIFO
- pool_rd_req  in  1  pooling line buffer requests a pixel
- pool_i_valid  out  1  pixel valid into pooling datapath
- pool_o_valid  in  1  pooled output produced (one pulse per window)
- down_almost_full  in  1  downstream FIFO almost full
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse, frame complete
- err  out  1  sticky protocol error; cleared by accepted start
- row_idx, col_idx  out  CNT_W  position of next input pixel
- out_cnt  out  OCNT_W  pooled outputs seen this frame

## Operation
Derived constants:
- OUT_W = (IN_WIDTH−KERNEL)/STRIDE+1
- OUT_H = (IN_HEIGHT−KERNEL)/STRIDE+1
- OUT_TOTAL = OUT_W·OUT_H
- CROP_COL = (IN_WIDTH−KERNEL) % STRIDE
- CROP_ROW = (IN_HEIGHT−KERNEL) % STRIDE
- CNT_W = $clog2(max(IN_WIDTH,IN_HEIGHT)+1)
- OCNT_W = $clog2(OUT_TOTAL+1)

Pixel crop rule: a pixel is a crop pixel when col_idx ≥ IN_WIDTH−CROP_COL or row_idx ≥ IN_HEIGHT−CROP_ROW.

FSM states (rst or abort → IDLE):
- IDLE:
  - start → RUN; row_idx, col_idx, out_cnt and err all cleared.
- RUN:
  - fifo_rd_en = !fifo_empty & !down_almost_full & (crop ? 1 : pool_rd_req).
  - pool_i_valid = fifo_rd_en & !crop. Crop pixels are popped and dropped.
  - On each fifo_rd_en: col_idx increments. At IN_WIDTH−1, col_idx wraps to 0 and row_idx increments.
  - Pop of pixel (IN_HEIGHT−1, IN_WIDTH−1) → DRAIN; row_idx and col_idx return to 0.
- DRAIN:
  - fifo_rd_en = 0 and pool_i_valid = 0.
  - pool_o_valid while out_cnt == OUT_TOTAL−1 → DONE.
- DONE:
  - done = 1 for exactly one cycle, then → IDLE. start is ignored in this state.

Output counting and errors:
- pool_o_valid increments out_cnt in RUN or DRAIN.
- If the final output arrives during RUN, DRAIN exits on the first DRAIN cycle. out_cnt reaching OUT_TOTAL is checked combinationally.
- pool_o_valid in IDLE or DONE sets err; out_cnt is not changed.
- start outside IDLE is ignored and does not set err.

abort:
- Clears counters, drops busy and emits no done.
- err keeps its value.

## Timing
- Reset values: fifo_rd_en, pool_i_valid, busy, done and err are 0; row_idx, col_idx and out_cnt are 0; state is IDLE.
- fifo_rd_en and pool_i_valid are combinational from state, counters and inputs. Pixel data passes straight from FIFO to pooling with zero added latency.
- Counters and state update on the edge ending the fifo_rd_en or pool_o_valid cycle.
- start accepted at edge N: busy = 1 from cycle N+1. The first read can occur in cycle N+1.
- done is registered (DONE-state decode). It is high in the cycle after the final pool_o_valid, and busy is 0 in that cycle.
- down_almost_full forces fifo_rd_en = 0 in the same cycle. Counters hold.
- Simultaneous abort and start in IDLE: abort wins and the state stays IDLE.
- Simultaneous final pop and pool_o_valid: both counters update.

## Structure
- Package pool_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - functions computing out_dim(in, k, s) and crop(in, k, s), shared with the pooling layer instances.
- One sub-module: pool_pos_counter, a parameterised row/col wrapping counter with an enable. It exposes last_col, last_row and a crop flag.

## Test plan
- 4×4, K=2, S=2, FIFO never empty, pool_rd_req always 1 → 16 pops, 16 pool_i_valid, 4 pool_o_valid → done 1 cycle after 4th, busy 0 then.
- 5×5 → 25 pops, pool_i_valid low at col 4 and at row 4 (9 crop pixels) → 16 valid, OUT_TOTAL 4, done.
- 4×4, down_almost_full high for 3 cycles mid-row → fifo_rd_en 0 those cycles, col_idx frozen, frame still totals 16 pops.
- abort after 7 pops → next cycle IDLE, busy 0, counters 0, no done; new start completes a full 4×4 frame normally.
- pool_o_valid pulsed in IDLE → err 1 and held; next start clears err. start during RUN → ignored, pop count unchanged.
- rst asserted in DRAIN → all outputs at reset values next cycle; late pool_o_valid afterwards sets err.
